uart_baud_gen_frac: RTL
=======================

Name: uart_baud_gen_frac

Overview:
Programmable, fractional-divisor baud generator for the UART. It replaces the fixed CLK/BAUD_RATE Tx tick generator. It produces a 1-cycle Tx bit tick and an independent Rx oversample tick, both from one divisor programmed at runtime. The Rx chain can be re-phased on a start-bit edge without disturbing Tx. It sits between the register interface (divisor load) and the uart_tx / uart_rx datapaths.

Parameters:
CLK, 64_000_000, system clock frequency in Hz (used only for the reset divisor)
BAUD_RATE, 250_000, reset-default baud rate in bit/s
OVERSAMPLE, 16, Rx oversample ticks per bit; also the Tx ticks-per-bit count; power of 2, minimum 4
DIV_W, 16, width of the integer divisor
FRAC_W, 4, width of the fractional divisor (units of 1/2^FRAC_W clock)

Ports:
sys_clk  in  1  system clock; all logic is on the rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = generators run; 0 = counters and accumulators hold, ticks forced to 0
div_int  in  DIV_W  integer part of the clocks-per-oversample-tick divisor
div_frac  in  FRAC_W  fractional part of the divisor
div_load  in  1  1-cycle strobe that captures div_int and div_frac into the shadow register
rx_sync  in  1  1-cycle strobe that restarts Rx chain phase (start-bit edge)
baud_rate_tx  out  1  1-cycle tick, one per Tx bit period
baud_rate_rx  out  1  1-cycle tick, OVERSAMPLE per bit period
div_pending  out  1  high while a loaded divisor is waiting to be applied

Behaviour:
- Reset divisor, computed at elaboration:
  - D0 = CLK*2^FRAC_W / (BAUD_RATE*OVERSAMPLE), truncated.
  - Reset int = D0 >> FRAC_W; reset frac = low FRAC_W bits of D0.
  - Defaults give int = 16, frac = 0.
- Reset values:
  - All outputs are 0.
  - Both chain counters are loaded for a first period of int cycles.
  - Accumulators = 0; Tx bit counter = 0; shadow and active divisor = reset divisor.
- All outputs are registered. No combinational path exists from any input to any output.
- Effective integer divisor = max(div_int, 2). Values 0 and 1 are clamped to 2.
- Fractional divider, identical for each chain (Tx chain and Rx chain are separate instances):
  - At each period start: acc_next = acc + frac (FRAC_W+1 bits); carry = bit FRAC_W; acc takes the low FRAC_W bits.
  - Period length = int + carry cycles.
  - The oversample tick asserts on the last cycle of each period.
  - Long-run mean period = int + frac/2^FRAC_W.
- Tx chain: counts its own oversample ticks modulo OVERSAMPLE. baud_rate_tx asserts for 1 cycle on the oversample tick that wraps the count from OVERSAMPLE-1 to 0.
- Rx chain: baud_rate_rx = the Rx oversample tick.
- rx_sync:
  - Reloads the Rx counter and clears the Rx accumulator.
  - The next baud_rate_rx asserts exactly int cycles after the rx_sync cycle.
  - If it coincides with a pending Rx tick, the tick is suppressed. rx_sync wins.
  - The Tx chain is unaffected.
- Divisor update:
  - div_load writes the shadow register and sets div_pending.
  - Each chain adopts the shadow value at its next period boundary. Periods are never truncated mid-way.
  - div_pending clears once both chains have adopted the new value.
  - A second div_load while pending overwrites the shadow; the last value wins.
  - If enable = 0, the load is applied to both chains immediately. Counters are reloaded and div_pending stays 0.
- enable:
  - Falling enable freezes state.
  - Rising enable resumes mid-period with no lost or extra tick.
  - enable = 0 during the tick cycle suppresses that tick. The counter does not advance.
- Reset mid-operation: asynchronous return to reset values within the same cycle. The programmed divisor is lost and the reset divisor applies.
- Simultaneous div_load and rx_sync: the Rx chain restarts with the new divisor.

Test Plan:
- Reset release, enable = 1, defaults → baud_rate_rx every 16 cycles (first at cycle 16); baud_rate_tx every 256 cycles (first at cycle 256); div_pending = 0.
- Load int = 3, frac = 8 (0.5) → Rx periods alternate 3,4,3,4 starting after the current period completes; 10 ticks span exactly 35 cycles; Tx bit = 56 cycles.
- Load int = 1 → behaves as int = 2, with a tick every 2 cycles; load int = 0 → same.
- rx_sync issued 5 cycles into a 16-cycle period → next baud_rate_rx 16 cycles after rx_sync; baud_rate_tx spacing stays 256 with unchanged phase.
- Drop enable for 40 cycles mid-period → tick spacing across the gap = 16 + 40; no extra or missing ticks; div_load during the gap takes effect on resume with div_pending = 0.
- Assert rst_n = 0 mid-period after int = 3 is loaded → outputs 0 immediately; after release, 16-cycle spacing is restored.

Source files
------------

// File: rtl/uart_baud_gen_frac_if.sv
// uart_baud_gen_frac_if
//   Bundles the divisor-programming, control and tick signals of the
//   fractional baud generator.
//   master : register interface / datapath side (drives control, reads ticks)
//   slave  : the baud generator itself
//   Signals:
//     enable       run (1) / freeze (0) both generators
//     div_int      integer part of the clocks-per-oversample-tick divisor
//     div_frac     fractional part, units of 1/2^FRAC_W clock
//     div_load     1-cycle strobe capturing div_int/div_frac into the shadow
//     rx_sync      1-cycle strobe restarting the Rx chain phase
//     baud_rate_tx 1-cycle tick per Tx bit period
//     baud_rate_rx 1-cycle tick, OVERSAMPLE per bit period
//     div_pending  a loaded divisor is still waiting to be adopted
interface uart_baud_gen_frac_if #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
);
    logic              enable;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              rx_sync;
    logic              baud_rate_tx;
    logic              baud_rate_rx;
    logic              div_pending;

    modport master (
        output enable, div_int, div_frac, div_load, rx_sync,
        input  baud_rate_tx, baud_rate_rx, div_pending
    );

    modport slave (
        input  enable, div_int, div_frac, div_load, rx_sync,
        output baud_rate_tx, baud_rate_rx, div_pending
    );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac
//   Runtime-programmable fractional baud generator. Two identical fractional
//   dividers (Tx chain, Rx chain) share one shadow divisor. The Rx chain
//   emits the oversample tick directly; the Tx chain divides its own
//   oversample ticks by OVERSAMPLE to give one tick per bit. The Rx chain
//   can be re-phased by rx_sync without touching the Tx chain.
//   Ports:
//     sys_clk  system clock, rising edge
//     rst_n    asynchronous active-low reset
//     bus      slave side of uart_baud_gen_frac_if (control in, ticks out)
module uart_baud_gen_frac #(
    parameter int unsigned CLK        = 64_000_000,
    parameter int unsigned BAUD_RATE  = 250_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 4
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    uart_baud_gen_frac_if.slave bus
);

    // Counter holds up to max int plus one carry cycle.
    localparam int unsigned CNT_W = DIV_W + 1;
    localparam int unsigned BIT_W = $clog2(OVERSAMPLE);

    // Reset divisor in fixed point: int.frac clocks per oversample tick.
    localparam logic [63:0]       D0       = (64'(CLK) << FRAC_W) /
                                             (64'(BAUD_RATE) * 64'(OVERSAMPLE));
    localparam logic [DIV_W-1:0]  D0_INT   = D0[FRAC_W +: DIV_W];
    localparam logic [DIV_W-1:0]  RST_INT  = (D0_INT < DIV_W'(2)) ? DIV_W'(2) : D0_INT;
    localparam logic [FRAC_W-1:0] RST_FRAC = D0[FRAC_W-1:0];

    typedef struct packed {
        logic [DIV_W-1:0]  int_part;   // already clamped to >= 2
        logic [FRAC_W-1:0] frac_part;
    } div_t;

    typedef struct packed {
        logic [CNT_W-1:0]  cnt;        // cycles left in the current period, 1 = last
        logic [FRAC_W-1:0] acc;        // fractional accumulator
        logic              pend;       // shadow holds a value this chain has not adopted
    } chain_t;

    localparam div_t   RST_DIV   = '{int_part: RST_INT, frac_part: RST_FRAC};
    localparam chain_t RST_CHAIN = '{cnt: CNT_W'(RST_INT), acc: '0, pend: 1'b0};

    // One fractional-divider step. A chain only ever reads the divisor at a
    // period boundary or a restart, so the shadow value seen at that moment
    // is by definition the adopted one; mid-period periods are never cut.
    function automatic chain_t chain_step(
        input chain_t cur,
        input logic   run,
        input logic   restart,
        input logic   load,
        input div_t   dv
    );
        chain_t          nxt;
        logic            adopt;
        logic [FRAC_W:0] sum;
        nxt   = cur;
        adopt = 1'b0;
        sum   = {1'b0, cur.acc} + {1'b0, dv.frac_part};
        if (restart) begin
            // Restart gives a clean int-cycle period with no carry history.
            nxt.cnt = CNT_W'(dv.int_part);
            nxt.acc = '0;
            adopt   = 1'b1;
        end else if (run) begin
            if (cur.cnt == CNT_W'(1)) begin
                nxt.cnt = CNT_W'(dv.int_part) + CNT_W'(sum[FRAC_W]);
                nxt.acc = sum[FRAC_W-1:0];
                adopt   = 1'b1;
            end else begin
                nxt.cnt = cur.cnt - CNT_W'(1);
            end
        end
        nxt.pend = (cur.pend | load) & ~adopt;
        return nxt;
    endfunction

    div_t             shadow_q, shadow_d;
    chain_t           tx_q, tx_d;
    chain_t           rx_q, rx_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             baud_tx_q, baud_tx_d;
    logic             baud_rx_q, baud_rx_d;
    logic             pending_q, pending_d;
    logic             load_off;
    logic             tx_boundary;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        shadow_d    = shadow_q;
        load_off    = bus.div_load & ~bus.enable;
        tx_boundary = bus.enable & (tx_q.cnt == CNT_W'(1));
        if (bus.div_load) begin
            shadow_d.int_part  = (bus.div_int < DIV_W'(2)) ? DIV_W'(2) : bus.div_int;
            shadow_d.frac_part = bus.div_frac;
        end

        // While disabled a load is applied to both chains at once.
        tx_d = chain_step(tx_q, bus.enable, load_off, bus.div_load, shadow_d);
        rx_d = chain_step(rx_q, bus.enable, load_off | bus.rx_sync, bus.div_load, shadow_d);

        bit_cnt_d = tx_boundary ? bit_cnt_q + BIT_W'(1) : bit_cnt_q;
        baud_tx_d = tx_boundary & (bit_cnt_q == BIT_W'(OVERSAMPLE - 1));
        // rx_sync wins over a tick due in the same cycle.
        baud_rx_d = bus.enable & (rx_q.cnt == CNT_W'(1)) & ~bus.rx_sync;
        pending_d = tx_d.pend | rx_d.pend;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= RST_DIV;
            tx_q      <= RST_CHAIN;
            rx_q      <= RST_CHAIN;
            bit_cnt_q <= '0;
            baud_tx_q <= 1'b0;
            baud_rx_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            baud_tx_q <= baud_tx_d;
            baud_rx_q <= baud_rx_d;
            pending_q <= pending_d;
        end
    end

    assign bus.baud_rate_tx = baud_tx_q;
    assign bus.baud_rate_rx = baud_rx_q;
    assign bus.div_pending  = pending_q;

endmodule
